// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared types and constants for the player life controller.
// Revision    : 1.0  initial release
// ============================================================================
package life_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } life_state_t;

  localparam int LIFE_W   = 3;
  localparam int LIFE_CAP = 7;

  // Saturating increment: never exceeds the ceiling nor the representable cap.
  function automatic logic [LIFE_W-1:0] sat_inc(input logic [LIFE_W-1:0] life,
                                                input logic [LIFE_W-1:0] ceiling);
    logic [LIFE_W-1:0] res;
    res = life;
    if ((life < ceiling) && (life != LIFE_W'(LIFE_CAP))) begin
      res = life + 1'b1;
    end
    return res;
  endfunction

endpackage : life_pkg
`default_nettype wire

// File: rtl/frame_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_down_counter
// Description : Loadable down-counter advanced by a frame tick. o_zero flags
//               the tick on which the count reaches zero, so the owner can
//               react in the same cycle and see the effect one cycle later.
// Revision    : 1.0  initial release
// ============================================================================
module frame_down_counter #(
  parameter int W        = 4,
  parameter int LOAD_VAL = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_tick,
  output logic o_zero
);

  localparam logic [W-1:0] c_LOAD = W'(LOAD_VAL);
  localparam logic [W-1:0] c_ONE  = W'(1);

  logic [W-1:0] r_count;

  // Count register: clear beats load beats tick; parks at zero, never wraps.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_LOAD;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = i_tick && (r_count == c_ONE);

endmodule : frame_down_counter
`default_nettype wire

// File: rtl/life_manager.sv
`default_nettype none
// ============================================================================
// Module      : life_manager
// Description : Player life-count controller. Applies hits and bonuses,
//               times a frame-counted invulnerability window with sprite
//               blink, and flags game over. All outputs are registered.
// Revision    : 1.0  initial release
// ============================================================================
module life_manager
  import life_pkg::*;
#(
  parameter int INIT_LIFE     = 3,
  parameter int MAX_LIFE      = 5,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              hitPulse,
  input  logic              bonusPulse,
  input  logic              newGame,
  output logic [LIFE_W-1:0] currLife,
  output logic              invulnerable,
  output logic              blinkOn,
  output logic              lifeLost,
  output logic              gameOver
);

  localparam int FRAME_W = $clog2(INVULN_FRAMES + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [LIFE_W-1:0] c_INIT_LIFE = LIFE_W'(INIT_LIFE);
  localparam logic [LIFE_W-1:0] c_MAX_LIFE  = LIFE_W'(MAX_LIFE);
  localparam logic [LIFE_W-1:0] c_ONE_LIFE  = LIFE_W'(1);

  life_state_t       r_state;
  life_state_t       w_state_nx;
  logic [LIFE_W-1:0] r_life;
  logic [LIFE_W-1:0] w_life_nx;
  logic              r_blink;
  logic              w_blink_nx;
  logic              r_lost;
  logic              w_lost_nx;
  logic              r_invuln;
  logic              r_over;

  logic w_tick;
  logic w_enter_invuln;
  logic w_frame_zero;
  logic w_blink_zero;

  // Counters only advance on frame ticks while invulnerable; the hit cycle
  // loads them instead, so a coincident frame tick is not counted.
  assign w_tick         = (r_state == INVULN) && startOfFrame;
  assign w_enter_invuln = (r_state == PLAY) && hitPulse && !newGame && (r_life > c_ONE_LIFE);

  frame_down_counter #(
    .W        (FRAME_W),
    .LOAD_VAL (INVULN_FRAMES)
  ) u_frame_cnt (
    .clk    (clk),
    .resetN (resetN),
    .i_clr  (newGame),
    .i_load (w_enter_invuln),
    .i_tick (w_tick),
    .o_zero (w_frame_zero)
  );

  // The blink counter reloads itself on each expiry to produce a periodic toggle.
  frame_down_counter #(
    .W        (BLINK_W),
    .LOAD_VAL (BLINK_FRAMES)
  ) u_blink_cnt (
    .clk    (clk),
    .resetN (resetN),
    .i_clr  (newGame),
    .i_load (w_enter_invuln || w_blink_zero),
    .i_tick (w_tick),
    .o_zero (w_blink_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= PLAY;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and next-output logic; priority newGame > hit > bonus.
  always_comb begin
    w_state_nx = r_state;
    w_life_nx  = r_life;
    w_blink_nx = r_blink;
    w_lost_nx  = 1'b0;
    if (newGame) begin
      w_state_nx = PLAY;
      w_life_nx  = c_INIT_LIFE;
      w_blink_nx = 1'b1;
    end else begin
      case (r_state)
        PLAY: begin
          if (hitPulse) begin
            w_lost_nx = 1'b1;
            if (r_life > c_ONE_LIFE) begin
              w_life_nx  = r_life - 1'b1;
              w_state_nx = INVULN;
              w_blink_nx = 1'b0;
            end else begin
              w_life_nx  = '0;
              w_state_nx = GAME_OVER;
            end
          end else if (bonusPulse) begin
            w_life_nx = sat_inc(r_life, c_MAX_LIFE);
          end
        end
        INVULN: begin
          if (bonusPulse) begin
            w_life_nx = sat_inc(r_life, c_MAX_LIFE);
          end
          if (w_frame_zero) begin
            w_state_nx = PLAY;
            w_blink_nx = 1'b1;
          end else if (w_blink_zero) begin
            w_blink_nx = !r_blink;
          end
        end
        GAME_OVER: begin
          w_life_nx  = '0;
          w_blink_nx = 1'b1;
        end
        default: begin
          w_state_nx = PLAY;
        end
      endcase
    end
  end

  // Output registers, all loaded from the next-cycle values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_life   <= c_INIT_LIFE;
      r_blink  <= 1'b1;
      r_lost   <= 1'b0;
      r_invuln <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_life   <= w_life_nx;
      r_blink  <= w_blink_nx;
      r_lost   <= w_lost_nx;
      r_invuln <= (w_state_nx == INVULN);
      r_over   <= (w_state_nx == GAME_OVER);
    end
  end

  assign currLife     = r_life;
  assign invulnerable = r_invuln;
  assign blinkOn      = r_blink;
  assign lifeLost     = r_lost;
  assign gameOver     = r_over;

endmodule : life_manager
`default_nettype wire

// File: tb/tb_life_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_manager
// Description : Self-checking bench for life_manager: directed scenarios with
//               literal expectations, then randomized pulses compared every
//               cycle against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_life_manager;

  localparam int INIT_LIFE     = 3;
  localparam int MAX_LIFE      = 5;
  localparam int INVULN_FRAMES = 120;
  localparam int BLINK_FRAMES  = 8;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       hitPulse = 1'b0;
  logic       bonusPulse = 1'b0;
  logic       newGame = 1'b0;
  logic [2:0] currLife;
  logic       invulnerable;
  logic       blinkOn;
  logic       lifeLost;
  logic       gameOver;

  int n_tests = 0;
  int n_fail  = 0;

  life_manager #(
    .INIT_LIFE     (INIT_LIFE),
    .MAX_LIFE      (MAX_LIFE),
    .INVULN_FRAMES (INVULN_FRAMES),
    .BLINK_FRAMES  (BLINK_FRAMES)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .hitPulse     (hitPulse),
    .bonusPulse   (bonusPulse),
    .newGame      (newGame),
    .currLife     (currLife),
    .invulnerable (invulnerable),
    .blinkOn      (blinkOn),
    .lifeLost     (lifeLost),
    .gameOver     (gameOver)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=play, 1=invulnerable, 2=game over.
  // ticks counts frame ticks since the window opened; blink follows from it.
  typedef struct {
    int mode;
    int life;
    int ticks;
    bit blink;
    bit lost;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode  = 0;
    r.life  = INIT_LIFE;
    r.ticks = 0;
    r.blink = 1'b1;
    r.lost  = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit s, bit h, bit b, bit n);
    mdl_t r;
    r = m;
    r.lost = 1'b0;
    if (n) return mdl_reset();
    if (m.mode == 0) begin
      if (h) begin
        r.lost = 1'b1;
        if (m.life > 1) begin
          r.life  = m.life - 1;
          r.mode  = 1;
          r.ticks = 0;
          r.blink = 1'b0;
        end else begin
          r.life = 0;
          r.mode = 2;
        end
      end else if (b) begin
        r.life = (m.life + 1 > MAX_LIFE) ? MAX_LIFE : m.life + 1;
      end
    end else if (m.mode == 1) begin
      if (b) r.life = (m.life + 1 > MAX_LIFE) ? MAX_LIFE : m.life + 1;
      if (s) begin
        r.ticks = m.ticks + 1;
        if (r.ticks >= INVULN_FRAMES) begin
          r.mode  = 0;
          r.blink = 1'b1;
        end else begin
          r.blink = ((r.ticks / BLINK_FRAMES) % 2) == 1;
        end
      end
    end
    return r;
  endfunction

  mdl_t m;

  // Model advances on the same edge as the DUT; reset is asynchronous too.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) m <= mdl_reset();
    else         m <= mdl_step(m, startOfFrame, hitPulse, bonusPulse, newGame);
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (resetN) begin
      n_tests = n_tests + 1;
      if ((int'(currLife) != m.life) || (invulnerable != (m.mode == 1)) ||
          (blinkOn != m.blink) || (lifeLost != m.lost) || (gameOver != (m.mode == 2))) begin
        n_fail = n_fail + 1;
        $display("FAIL model t=%0t: got life=%0d inv=%0b blink=%0b lost=%0b go=%0b, expected life=%0d inv=%0b blink=%0b lost=%0b go=%0b",
                 $time, currLife, invulnerable, blinkOn, lifeLost, gameOver,
                 m.life, (m.mode == 1), m.blink, m.lost, (m.mode == 2));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given pulses; returns 1 time unit after the edge.
  task automatic step(input bit s, input bit h, input bit b, input bit n);
    startOfFrame = s;
    hitPulse     = h;
    bonusPulse   = b;
    newGame      = n;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    hitPulse     = 1'b0;
    bonusPulse   = 1'b0;
    newGame      = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    int exp_bonus [6];
    exp_bonus = '{4, 5, 5, 5, 5, 5};

    // Reset and idle.
    #2 resetN = 1'b0;
    #1;
    chk("reset_life", currLife, 3);
    chk("reset_blink", blinkOn, 1);
    chk("reset_inv", invulnerable, 0);
    chk("reset_lost", lifeLost, 0);
    chk("reset_over", gameOver, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      frames(1);
      chk("idle_life", currLife, 3);
      chk("idle_blink", blinkOn, 1);
    end

    // Hit, ignored second hit, blink pattern and window length.
    step(0, 1, 0, 0);
    chk("hit_life", currLife, 2);
    chk("hit_lost", lifeLost, 1);
    chk("hit_inv", invulnerable, 1);
    chk("hit_blink", blinkOn, 0);
    step(0, 0, 0, 0);
    chk("hit_lost_one_cycle", lifeLost, 0);
    frames(5);
    step(0, 1, 0, 0);
    chk("ignored_hit_life", currLife, 2);
    chk("ignored_hit_lost", lifeLost, 0);
    for (int t = 6; t <= INVULN_FRAMES; t++) begin
      step(1, 0, 0, 0);
      if (t == 7)   chk("blink_before_8", blinkOn, 0);
      if (t == 8)   chk("blink_at_8", blinkOn, 1);
      if (t == 16)  chk("blink_at_16", blinkOn, 0);
      if (t == 119) chk("inv_at_119", invulnerable, 1);
    end
    chk("inv_end", invulnerable, 0);
    chk("inv_end_blink", blinkOn, 1);

    // Bonus saturation.
    step(0, 0, 0, 1);
    chk("newgame_life", currLife, 3);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0);
      chk("bonus_seq", currLife, exp_bonus[i]);
    end

    // Three hits to game over, each immediately after the window closes.
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    chk("hit1_life", currLife, 2);
    for (int t = 0; t < INVULN_FRAMES; t++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("hit2_life", currLife, 1);
    chk("hit2_lost", lifeLost, 1);
    for (int t = 0; t < INVULN_FRAMES; t++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("hit3_life", currLife, 0);
    chk("hit3_over", gameOver, 1);
    chk("hit3_lost", lifeLost, 1);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    chk("over_hold_life", currLife, 0);
    chk("over_hold_lost", lifeLost, 0);
    chk("over_blink", blinkOn, 1);

    // Simultaneous pulses.
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int t = 0; t < INVULN_FRAMES; t++) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("hit_bonus_life", currLife, 1);
    chk("hit_bonus_inv", invulnerable, 1);
    step(1, 1, 1, 0);
    chk("inv_bonus_life", currLife, 2);
    step(0, 1, 0, 1);
    chk("ng_hit_life", currLife, 3);
    chk("ng_hit_inv", invulnerable, 0);
    chk("ng_hit_lost", lifeLost, 0);

    // Asynchronous reset in the middle of the window.
    step(0, 1, 0, 0);
    frames(3);
    chk("pre_reset_blink", blinkOn, 0);
    #2 resetN = 1'b0;
    #1;
    chk("async_life", currLife, 3);
    chk("async_inv", invulnerable, 0);
    chk("async_blink", blinkOn, 1);
    @(negedge clk);
    resetN = 1'b1;
    step(1, 0, 0, 0);
    chk("post_reset_life", currLife, 3);
    chk("post_reset_inv", invulnerable, 0);
    chk("post_reset_lost", lifeLost, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 1499) == 0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_life_manager
`default_nettype wire
